pulse_gen_mc: RTL and testbench

Multi-channel, parametrised edge-to-pulse generator for asynchronous or slow control inputs. Each channel:
- synchronises its input through a configurable flop chain;
- detects the edge type chosen by a shared runtime MODE;
- emits a registered output pulse of programmable length, with optional retrigger.
Sits between register-file/UART-side control strobes and the processing core, replacing single-bit, single-cycle rising-edge pulse logic.

---
 rtl/pulse_gen_mc_if.sv | 35 +++
 rtl/pulse_gen_mc.sv | 142 ++++++++++++++
 tb/tb_pulse_gen_mc.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_mc_if.sv
// ---------------------------------------------------------------------------
// pulse_gen_mc_if
// Bundles the channel-side signals of pulse_gen_mc.
//   IN      : raw channel inputs, asynchronous to clk (driven by master)
//   MODE    : shared edge select 00 rise / 01 fall / 10 both / 11 off
//   OUT     : per-channel registered pulse outputs (driven by slave)
//   BUSY    : per-channel pulse-active flag, equal to OUT
//   EVT_CLR : synchronous clear of event counters (PULSE_GEN_MC_EVT_CNT_EN only)
//   EVT_CNT : per-channel accepted-event counts, channel 0 in LSBs
//             (PULSE_GEN_MC_EVT_CNT_EN only)
// Optional signals exist only when the macro PULSE_GEN_MC_EVT_CNT_EN is defined.
// ---------------------------------------------------------------------------
interface pulse_gen_mc_if #(
    parameter int NUM_CH = 4,
    parameter int EVT_W  = 8
);
    logic [NUM_CH-1:0]       IN;
    logic [1:0]              MODE;
    logic [NUM_CH-1:0]       OUT;
    logic [NUM_CH-1:0]       BUSY;
`ifdef PULSE_GEN_MC_EVT_CNT_EN
    logic                    EVT_CLR;
    logic [NUM_CH*EVT_W-1:0] EVT_CNT;

    modport master (output IN, MODE, EVT_CLR, input  OUT, BUSY, EVT_CNT);
    modport slave  (input  IN, MODE, EVT_CLR, output OUT, BUSY, EVT_CNT);
`else
    modport master (output IN, MODE, input  OUT, BUSY);
    modport slave  (input  IN, MODE, output OUT, BUSY);
`endif

    if (NUM_CH < 1 || EVT_W < 1) begin : g_bad_param
        $error("pulse_gen_mc_if: NUM_CH and EVT_W must be >= 1");
    end
endinterface

// File: rtl/pulse_gen_mc.sv
// ---------------------------------------------------------------------------
// pulse_gen_mc
// Multi-channel edge-to-pulse generator. Each channel synchronises its raw
// input through SYNC_STAGES flops, detects the edge type selected by the
// shared MODE and emits a registered pulse PULSE_LEN cycles long. With
// RETRIG=1 an event during an active pulse reloads the length; with RETRIG=0
// it is ignored until the counter has reached zero.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : pulse_gen_mc_if.slave (IN, MODE, OUT, BUSY [, EVT_CLR, EVT_CNT])
// Optional feature macro: PULSE_GEN_MC_EVT_CNT_EN adds saturating per-channel
// accepted-event counters with a synchronous clear.
// ---------------------------------------------------------------------------
module pulse_gen_mc #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 4,
    parameter int PULSE_LEN   = 1,
    parameter int RETRIG      = 1,
    parameter int EVT_W       = 8
) (
    input  logic          clk,
    input  logic          rst,
    pulse_gen_mc_if.slave bus
);
    if (PULSE_LEN < 1 || PULSE_LEN > (2**PULSE_W) - 1 || SYNC_STAGES < 1 ||
        NUM_CH < 1 || EVT_W < 1) begin : g_bad_param
        $error("pulse_gen_mc: illegal PULSE_LEN / PULSE_W / SYNC_STAGES / NUM_CH / EVT_W");
    end

    localparam logic [PULSE_W-1:0] LEN_C = PULSE_W'(PULSE_LEN);
    localparam logic [PULSE_W-1:0] ONE_C = PULSE_W'(1);

    logic [NUM_CH-1:0]  sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]  prev_q;
    logic [NUM_CH-1:0]  s_w;
    logic [NUM_CH-1:0]  rise_w;
    logic [NUM_CH-1:0]  fall_w;
    logic [NUM_CH-1:0]  evt_w;
    logic [NUM_CH-1:0]  accept_w;
    logic [PULSE_W-1:0] cnt_q [NUM_CH];
    logic [PULSE_W-1:0] cnt_d [NUM_CH];
    logic [NUM_CH-1:0]  out_q;
    logic [NUM_CH-1:0]  out_d;

    // Synchroniser chain and previous-value register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= bus.IN;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= s_w;
        end
    end

    assign s_w = sync_q[SYNC_STAGES-1];

    // Edge detection uses the MODE of the current cycle, so a MODE change
    // applies to edges seen in the same cycle.
    always_comb begin
        rise_w = s_w & ~prev_q;
        fall_w = ~s_w & prev_q;
        case (bus.MODE)
            2'b00:   evt_w = rise_w;
            2'b01:   evt_w = fall_w;
            2'b10:   evt_w = rise_w | fall_w;
            default: evt_w = '0;
        endcase
    end

    // Pulse counter next state. MODE only gates new events; a running count
    // always drains, so in-flight pulses are never truncated. With RETRIG=0
    // an event in the cycle the count goes 1->0 is still rejected, which
    // guarantees a low gap between consecutive pulses.
    always_comb begin
        accept_w = '0;
        out_d    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c]    = '0;
            accept_w[c] = evt_w[c] & ((RETRIG != 0) || (cnt_q[c] == '0));
            if (accept_w[c]) begin
                cnt_d[c] = LEN_C;
                out_d[c] = 1'b1;
            end else if (cnt_q[c] > ONE_C) begin
                cnt_d[c] = cnt_q[c] - ONE_C;
                out_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
            out_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            out_q <= out_d;
        end
    end

    assign bus.OUT  = out_q;
    assign bus.BUSY = out_q;

`ifdef PULSE_GEN_MC_EVT_CNT_EN
    logic [EVT_W-1:0] ecnt_q [NUM_CH];

    // Saturating accepted-event counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ecnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.EVT_CLR) begin
                    ecnt_q[c] <= '0;
                end else if (accept_w[c] && (ecnt_q[c] != '1)) begin
                    ecnt_q[c] <= ecnt_q[c] + EVT_W'(1);
                end
            end
        end
    end

    always_comb begin
        bus.EVT_CNT = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.EVT_CNT[c*EVT_W +: EVT_W] = ecnt_q[c];
        end
    end
`endif
endmodule

// File: tb/tb_pulse_gen_mc.sv
// ---------------------------------------------------------------------------
// tb_pulse_gen_mc
// Three pulse_gen_mc instances share one stimulus:
//   dut0 : SYNC_STAGES=2, PULSE_LEN=1, RETRIG=1, EVT_W=2
//   dut1 : SYNC_STAGES=2, PULSE_LEN=4, RETRIG=1
//   dut2 : SYNC_STAGES=3, PULSE_LEN=4, RETRIG=0
// The reference model keeps a history of sampled inputs and, per channel,
// the last edge index on which the output is expected to be high.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_gen_mc;
    localparam int NUM_CH = 4;
    localparam int NI     = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] in_drv;
    logic [1:0]        mode_drv;
    logic              clr_drv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_gen_mc_if #(.NUM_CH(NUM_CH), .EVT_W(2)) if0 ();
    pulse_gen_mc_if #(.NUM_CH(NUM_CH), .EVT_W(8)) if1 ();
    pulse_gen_mc_if #(.NUM_CH(NUM_CH), .EVT_W(8)) if2 ();

    assign if0.IN = in_drv;   assign if0.MODE = mode_drv;
    assign if1.IN = in_drv;   assign if1.MODE = mode_drv;
    assign if2.IN = in_drv;   assign if2.MODE = mode_drv;
`ifdef PULSE_GEN_MC_EVT_CNT_EN
    assign if0.EVT_CLR = clr_drv;
    assign if1.EVT_CLR = clr_drv;
    assign if2.EVT_CLR = clr_drv;
    logic [31:0] evt_a [NI];
    assign evt_a[0] = {24'b0, if0.EVT_CNT};
    assign evt_a[1] = if1.EVT_CNT;
    assign evt_a[2] = if2.EVT_CNT;
`endif

    pulse_gen_mc #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .PULSE_W(4), .PULSE_LEN(1),
                   .RETRIG(1), .EVT_W(2)) u_dut0 (.clk(clk), .rst(rst_n), .bus(if0.slave));
    pulse_gen_mc #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .PULSE_W(4), .PULSE_LEN(4),
                   .RETRIG(1), .EVT_W(8)) u_dut1 (.clk(clk), .rst(rst_n), .bus(if1.slave));
    pulse_gen_mc #(.NUM_CH(NUM_CH), .SYNC_STAGES(3), .PULSE_W(4), .PULSE_LEN(4),
                   .RETRIG(0), .EVT_W(8)) u_dut2 (.clk(clk), .rst(rst_n), .bus(if2.slave));

    logic [NUM_CH-1:0] out_a  [NI];
    logic [NUM_CH-1:0] busy_a [NI];
    assign out_a[0] = if0.OUT;  assign busy_a[0] = if0.BUSY;
    assign out_a[1] = if1.OUT;  assign busy_a[1] = if1.BUSY;
    assign out_a[2] = if2.OUT;  assign busy_a[2] = if2.BUSY;

    // ---------------- reference model ----------------
    function automatic int s_of(int i); return (i == 2) ? 3 : 2; endfunction
    function automatic int l_of(int i); return (i == 0) ? 1 : 4; endfunction
    function automatic bit r_of(int i); return (i != 2);         endfunction
    function automatic int w_of(int i); return (i == 0) ? 2 : 8; endfunction

    int                edge_n = 0;
    logic [NUM_CH-1:0] hist_q [$];        // hist_q[0] = input sampled at previous edge
    int                busy_until [NI][NUM_CH];
    int                evcnt      [NI][NUM_CH];

    task automatic model_reset();
        hist_q = {};
        for (int k = 0; k < 8; k++) hist_q.push_front('0);
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < NUM_CH; c++) begin
                busy_until[i][c] = -100;
                evcnt[i][c]      = 0;
            end
    endtask

    task automatic model_step();
        bit s, p, ev, acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        edge_n++;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                s = hist_q[s_of(i)-1][c];
                p = hist_q[s_of(i)][c];
                case (mode_drv)
                    2'b00:   ev = s && !p;
                    2'b01:   ev = !s && p;
                    2'b10:   ev = (s != p);
                    default: ev = 1'b0;
                endcase
                acc = ev && (r_of(i) || (busy_until[i][c] < edge_n - 1));
                if (acc) busy_until[i][c] = edge_n + l_of(i) - 1;
                if (clr_drv) evcnt[i][c] = 0;
                else if (acc && evcnt[i][c] < (1 << w_of(i)) - 1) evcnt[i][c]++;
            end
        end
        hist_q.push_front(in_drv);
        if (hist_q.size() > 8) void'(hist_q.pop_back());
    endtask

    function automatic logic [NUM_CH-1:0] exp_out(int i);
        logic [NUM_CH-1:0] e = '0;
        for (int c = 0; c < NUM_CH; c++) e[c] = (edge_n <= busy_until[i][c]);
        return e;
    endfunction

    function automatic logic [31:0] exp_evt(int i);
        logic [31:0] e = '0;
        for (int c = 0; c < NUM_CH; c++) e |= 32'(evcnt[i][c]) << (c * w_of(i));
        return e;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] e;
        for (int i = 0; i < NI; i++) begin
            e = exp_out(i);
            checks++;
            assert (out_a[i] === e) else begin
                errors++;
                $error("FAIL out_dut%0d edge=%0d observed=%b expected=%b", i, edge_n, out_a[i], e);
            end
            checks++;
            assert (busy_a[i] === e) else begin
                errors++;
                $error("FAIL busy_dut%0d edge=%0d observed=%b expected=%b", i, edge_n, busy_a[i], e);
            end
`ifdef PULSE_GEN_MC_EVT_CNT_EN
            checks++;
            assert (evt_a[i] === exp_evt(i)) else begin
                errors++;
                $error("FAIL evtcnt_dut%0d edge=%0d observed=%h expected=%h", i, edge_n, evt_a[i], exp_evt(i));
            end
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n0, n1, n2;
        bit mode_set;
        in_drv = '0; mode_drv = 2'b00; clr_drv = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        chk("reset_out0", if0.OUT, 0);
        chk("reset_busy1", if1.BUSY, 0);
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        // Rising edge on ch0: latency SYNC_STAGES edges
        in_drv = 4'b0001;
        cycle(); chk("lat_e0", if0.OUT, 0);
        cycle(); chk("lat_e1", if0.OUT, 0);
        cycle(); chk("lat_e2_dut0", if0.OUT, 4'b0001);
                 chk("lat_e2_dut1", if1.OUT, 4'b0001);
                 chk("lat_e2_dut2", if2.OUT, 4'b0000);
        cycle(); chk("len1_end_dut0", if0.OUT, 0);
                 chk("s3_lat_dut2", if2.OUT, 4'b0001);
        repeat (6) cycle();

        // Both-edge mode on ch1: one pulse per edge
        mode_drv = 2'b10; in_drv = 4'b0011;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == 22) in_drv = 4'b0001;
            cycle();
            n0 += int'(if0.OUT[1]);
            n1 += int'(if1.OUT[1]);
        end
        chk("both_edges_dut0", n0, 2);
        chk("both_edges_dut1", n1, 8);

        // Retrigger: second rising edge on ch2 two cycles after the first
        mode_drv = 2'b00;
        n0 = 0; n1 = 0; n2 = 0;
        for (int k = 0; k < 14; k++) begin
            in_drv[2] = (k == 1) ? 1'b0 : 1'b1;
            cycle();
            n0 += int'(if0.OUT[2]);
            n1 += int'(if1.OUT[2]);
            n2 += int'(if2.OUT[2]);
        end
        chk("retrig_dut0", n0, 2);
        chk("retrig_on_dut1", n1, 6);
        chk("retrig_off_dut2", n2, 4);

        // MODE -> 11 one cycle into a pulse: pulse completes, no new pulses
        in_drv[3] = 1'b1; mode_set = 1'b0;
        n1 = 0; n2 = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            n1 += int'(if1.OUT[3]);
            n2 += int'(if2.OUT[3]);
            if (!mode_set && if1.OUT[3]) begin
                mode_drv = 2'b11;
                mode_set = 1'b1;
            end
        end
        chk("mode11_complete_dut1", n1, 4);
        chk("mode11_same_edge_dut2", n2, 0);
        n0 = 0;
        for (int k = 0; k < 12; k++) begin
            if (k % 3 == 0) in_drv[3] = ~in_drv[3];
            cycle();
            n0 += int'(if0.OUT != 0) + int'(if1.OUT != 0) + int'(if2.OUT != 0);
        end
        chk("mode11_silent", n0, 0);

        // Async reset mid-pulse, IN held high through release
        mode_drv = 2'b00; in_drv = 4'b0000;
        repeat (4) cycle();
        in_drv = 4'b1111;
        repeat (3) cycle();
        chk("all_ch_dut1", if1.OUT, 4'hF);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        chk("async_rst_out1", if1.OUT, 0);
        chk("async_rst_busy1", if1.BUSY, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle(); chk("rel_r1", if1.OUT, 0);
        cycle(); chk("rel_r2", if1.OUT, 0);
        cycle(); chk("rel_r3_dut1", if1.OUT, 4'hF);
                 chk("rel_r3_dut2", if2.OUT, 4'h0);
        cycle(); chk("rel_r4_dut2", if2.OUT, 4'hF);
        repeat (5) cycle();

`ifdef PULSE_GEN_MC_EVT_CNT_EN
        // Saturating event counter and clear priority
        in_drv = 4'b0000; clr_drv = 1'b1;
        repeat (2) cycle();
        clr_drv = 1'b0;
        for (int e = 0; e < 5; e++) begin
            in_drv = 4'b0100; repeat (3) cycle();
            in_drv = 4'b0000; repeat (3) cycle();
        end
        repeat (4) cycle();
        chk("evt_sat_dut0_ch2", if0.EVT_CNT[5:4], 2'd3);
        chk("evt_cnt_dut1_ch2", if1.EVT_CNT[23:16], 8'd5);
        clr_drv = 1'b1; in_drv = 4'b0100;
        repeat (5) cycle();
        clr_drv = 1'b0;
        cycle();
        chk("evt_clr_dut0_ch2", if0.EVT_CNT[5:4], 2'd0);
        chk("evt_clr_dut1_ch2", if1.EVT_CNT[23:16], 8'd0);
`endif

        // Randomised stimulus against the model
        for (int k = 0; k < 500; k++) begin
            in_drv = NUM_CH'($urandom);
            if ($urandom_range(0, 7) == 0) mode_drv = 2'($urandom);
`ifdef PULSE_GEN_MC_EVT_CNT_EN
            clr_drv = ($urandom_range(0, 15) == 0);
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
